// File: rtl/player_controller.sv
// Player movement controller: debounces one-hot button commands, turns the heading
// or steps forward after a collision lookup on the map req/ack port.
module player_controller #(
  parameter int MAP_W      = 16,
  parameter int MAP_H      = 16,
  parameter int DEB_CYCLES = 2,
  parameter int START_X    = 1,
  parameter int START_Y    = 1,
  parameter int START_DIR  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rotateCCW,
  input  logic                     forward,
  input  logic                     rotateCW,
  input  logic                     pressed,
  output logic                     map_req,
  output logic [$clog2(MAP_W)-1:0] map_x,
  output logic [$clog2(MAP_H)-1:0] map_y,
  input  logic                     map_ack,
  input  logic                     map_wall,
  output logic [$clog2(MAP_W)-1:0] pos_x,
  output logic [$clog2(MAP_H)-1:0] pos_y,
  output logic [1:0]               heading,
  output logic                     turned,
  output logic                     moved,
  output logic                     bumped,
  output logic                     busy
);
  localparam int XW    = $clog2(MAP_W);
  localparam int YW    = $clog2(MAP_H);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [XW-1:0]    X_MAX    = XW'(MAP_W - 1);
  localparam logic [YW-1:0]    Y_MAX    = YW'(MAP_H - 1);

  // command vector ordering: {ccw, fwd, cw}
  localparam logic [2:0] CMD_CCW = 3'b100;
  localparam logic [2:0] CMD_FWD = 3'b010;
  localparam logic [2:0] CMD_CW  = 3'b001;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, MAP_REQ, WAIT_RELEASE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       cmd_reg, cmd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             map_req_next, turned_next, moved_next, bumped_next, busy_next;
  logic [XW-1:0]    map_x_next, pos_x_next, tgt_x;
  logic [YW-1:0]    map_y_next, pos_y_next, tgt_y;
  logic [1:0]       heading_next;

  logic [2:0] cmd_in;
  logic       cmd_valid, deb_hit, deb_last, at_edge;

  assign cmd_in    = {rotateCCW, forward, rotateCW};
  assign cmd_valid = pressed && (cmd_in inside {CMD_CCW, CMD_FWD, CMD_CW});
  assign deb_hit   = pressed && (cmd_in == cmd_reg);
  assign deb_last  = deb_hit && (cnt_reg == DEB_LAST);

  always_comb begin
    tgt_x   = pos_x;
    tgt_y   = pos_y;
    at_edge = 1'b0;
    case (heading)
      2'd0: begin tgt_y = pos_y - YW'(1); at_edge = (pos_y == '0);    end
      2'd1: begin tgt_x = pos_x + XW'(1); at_edge = (pos_x == X_MAX); end
      2'd2: begin tgt_y = pos_y + YW'(1); at_edge = (pos_y == Y_MAX); end
      default: begin tgt_x = pos_x - XW'(1); at_edge = (pos_x == '0); end
    endcase
  end

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cmd_reg   <= '0;
      cnt_reg   <= '0;
      map_req   <= 1'b0;
      map_x     <= XW'(START_X);
      map_y     <= YW'(START_Y);
      pos_x     <= XW'(START_X);
      pos_y     <= YW'(START_Y);
      heading   <= 2'(START_DIR);
      turned    <= 1'b0;
      moved     <= 1'b0;
      bumped    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      cnt_reg   <= cnt_next;
      map_req   <= map_req_next;
      map_x     <= map_x_next;
      map_y     <= map_y_next;
      pos_x     <= pos_x_next;
      pos_y     <= pos_y_next;
      heading   <= heading_next;
      turned    <= turned_next;
      moved     <= moved_next;
      bumped    <= bumped_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pressed) state_next = cmd_valid ? DEBOUNCE : WAIT_RELEASE;
      end
      DEBOUNCE: begin
        if (!deb_hit)      state_next = pressed ? WAIT_RELEASE : IDLE;
        else if (deb_last) state_next = (cmd_reg == CMD_FWD && !at_edge) ? MAP_REQ : WAIT_RELEASE;
      end
      MAP_REQ: begin
        if (map_ack) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!pressed && cnt_reg == REL_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_next     = cmd_reg;
    cnt_next     = cnt_reg;
    map_req_next = map_req;
    map_x_next   = map_x;
    map_y_next   = map_y;
    pos_x_next   = pos_x;
    pos_y_next   = pos_y;
    heading_next = heading;
    turned_next  = 1'b0;
    moved_next   = 1'b0;
    bumped_next  = 1'b0;
    busy_next    = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        cmd_next = cmd_in;
        cnt_next = cmd_valid ? CNT_W'(1) : '0;
      end
      DEBOUNCE: begin
        if (!deb_hit) begin
          cnt_next = '0;
        end else if (!deb_last) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          cnt_next = '0;
          case (cmd_reg)
            CMD_CW:  begin heading_next = heading + 2'd1; turned_next = 1'b1; end
            CMD_CCW: begin heading_next = heading - 2'd1; turned_next = 1'b1; end
            default: begin
              // edge-of-map steps are rejected without touching the map port
              if (at_edge) begin
                bumped_next = 1'b1;
              end else begin
                map_req_next = 1'b1;
                map_x_next   = tgt_x;
                map_y_next   = tgt_y;
              end
            end
          endcase
        end
      end
      MAP_REQ: begin
        if (map_ack) begin
          map_req_next = 1'b0;
          cnt_next     = '0;
          if (map_wall) begin
            bumped_next = 1'b1;
          end else begin
            pos_x_next = map_x;
            pos_y_next = map_y;
            moved_next = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        cnt_next = pressed ? '0 : cnt_reg + CNT_W'(1);
      end
      default: cnt_next = '0;
    endcase
  end
endmodule
